// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding scoreboard.
// Stage index k counts stages after ID: 1=EX, 2=MEM, 3=WB.
package fwd_pkg;

  localparam int SEL_RF = 0;
  localparam int MAX_AW = 8;

  typedef struct packed {
    logic              vld;
    logic [MAX_AW-1:0] dest;
    logic              ld;
  } fwd_tag_t;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_port_match.sv
// Priority match of one ID source against the in-flight tags.
// Youngest matching stage wins; a too-young load flags load-use.
module fwd_port_match
  import fwd_pkg::*;
#(
  parameter int REG_AW     = 3,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = sel_w(DEPTH)
) (
  input  logic                   en_i,
  input  logic [REG_AW-1:0]      src_i,
  input  fwd_tag_t [DEPTH-1:0]   tag_i,
  output logic [SEL_W-1:0]       sel_o,
  output logic                   lu_o
);

  logic [MAX_AW-1:0] src_ext;

  assign src_ext = MAX_AW'(src_i);

  // Scan oldest to youngest so the youngest hit is the last write.
  always_comb begin
    sel_o = SEL_W'(SEL_RF);
    lu_o  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (en_i && tag_i[i].vld &&
          tag_i[i].dest == src_ext) begin
        lu_o  = tag_i[i].ld && (i + 1 < LOAD_STAGE);
        sel_o = lu_o ? SEL_W'(SEL_RF)
                     : SEL_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks in-flight destination tags and
// produces per-port bypass selects plus a load-use stall.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int REG_AW     = 3,
  parameter int NUM_SRC    = 3,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = sel_w(DEPTH),
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_dest_addr,
  input  logic                      id_dest_we,
  input  logic                      id_is_load,
  input  logic                      id_flush,
  input  logic                      stall_ext,
  output logic [NUM_SRC*SEL_W-1:0]  frwd_sel,
  output logic                      hazard_stall,
  output logic [CNT_W-1:0]          stall_cnt
);

  fwd_tag_t [DEPTH-1:0] tag_q, tag_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_SRC-1:0]   lu;
  logic                 issue;

  for (genvar p = 0; p < NUM_SRC; p++) begin : g_port
    logic [REG_AW-1:0] src;
    logic              en;

    assign src = id_src_addr[p*REG_AW +: REG_AW];
    assign en  = id_valid && id_src_used[p] &&
                 (src != '0);

    fwd_port_match #(
      .REG_AW    (REG_AW),
      .DEPTH     (DEPTH),
      .LOAD_STAGE(LOAD_STAGE),
      .SEL_W     (SEL_W)
    ) u_match (
      .en_i (en),
      .src_i(src),
      .tag_i(tag_q),
      .sel_o(frwd_sel[p*SEL_W +: SEL_W]),
      .lu_o (lu[p])
    );
  end

  assign hazard_stall = id_valid && !id_flush && (|lu);

  assign issue = id_valid && !id_flush && !hazard_stall &&
                 id_dest_we && (id_dest_addr != '0);

  always_comb begin
    tag_d = tag_q;
    for (int k = DEPTH - 1; k > 0; k--) begin
      tag_d[k] = tag_q[k-1];
    end
    tag_d[0] = '0;
    if (issue) begin
      tag_d[0].vld  = 1'b1;
      tag_d[0].dest = MAX_AW'(id_dest_addr);
      tag_d[0].ld   = id_is_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
      cnt_q <= '0;
    end else if (!stall_ext) begin
      tag_q <= tag_d;
      if (hazard_stall && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: default config plus a
// REG_AW=5/NUM_SRC=2/DEPTH=4/LOAD_STAGE=3/CNT_W=4 instance.
module tb_fwd_scoreboard;

  logic clk;
  logic rst_n;

  logic       v, we, ld, fl, se;
  logic [8:0] sa;
  logic [2:0] su;
  logic [2:0] da;
  logic [5:0] fs;
  logic       hz;
  logic [15:0] sc;

  logic       pv, pwe, pld, pfl, pse;
  logic [9:0] psa;
  logic [1:0] psu;
  logic [4:0] pda;
  logic [5:0] pfs;
  logic       phz;
  logic [3:0] pcnt;

  int n_cmp;
  int n_bad;

  fwd_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (v),
    .id_src_addr (sa),
    .id_src_used (su),
    .id_dest_addr(da),
    .id_dest_we  (we),
    .id_is_load  (ld),
    .id_flush    (fl),
    .stall_ext   (se),
    .frwd_sel    (fs),
    .hazard_stall(hz),
    .stall_cnt   (sc)
  );

  fwd_scoreboard #(
    .REG_AW    (5),
    .NUM_SRC   (2),
    .DEPTH     (4),
    .LOAD_STAGE(3),
    .CNT_W     (4)
  ) dut_p (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (pv),
    .id_src_addr (psa),
    .id_src_used (psu),
    .id_dest_addr(pda),
    .id_dest_we  (pwe),
    .id_is_load  (pld),
    .id_flush    (pfl),
    .stall_ext   (pse),
    .frwd_sel    (pfs),
    .hazard_stall(phz),
    .stall_cnt   (pcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    v = 0; we = 0; ld = 0; fl = 0; se = 0;
    sa = '0; su = '0; da = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    pv = 0; pwe = 0; pld = 0; pfl = 0; pse = 0;
    psa = '0; psu = '0; pda = '0;
    #3;
    v = 1; sa = {3'd3, 3'd2, 3'd1}; su = 3'b111;
    #1;
    n_cmp++;
    if (fs !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_sel got %h want 0", fs);
    end
    n_cmp++;
    if (hz !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hz got %b want 0", hz);
    end
    n_cmp++;
    if (sc !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_cnt got %0d want 0", sc);
    end
    n_cmp++;
    if (pcnt !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_pcnt got %0d want 0", pcnt);
    end
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp [4];
    exp[0] = 2'd1; exp[1] = 2'd2;
    exp[2] = 2'd3; exp[3] = 2'd0;
    @(negedge clk);
    v = 1; we = 1; da = 3'd3;
    @(negedge clk);
    we = 0; da = 3'd0;
    sa = {3'd0, 3'd0, 3'd3}; su = 3'b001;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (fs[1:0] !== exp[i]) begin
        n_bad++;
        $display("FAIL b2b_sel%0d got %0d want %0d",
                 i, fs[1:0], exp[i]);
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    v = 1; we = 1; ld = 1; da = 3'd2; su = '0;
    @(negedge clk);
    ld = 0; da = 3'd6;
    sa = {3'd0, 3'd2, 3'd0}; su = 3'b010;
    #1;
    n_cmp++;
    if (hz !== 1'b1) begin
      n_bad++;
      $display("FAIL lu_hz got %b want 1", hz);
    end
    n_cmp++;
    if (fs[3:2] !== 2'd0) begin
      n_bad++;
      $display("FAIL lu_sel got %0d want 0", fs[3:2]);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (hz !== 1'b0) begin
      n_bad++;
      $display("FAIL lu_release got %b want 0", hz);
    end
    n_cmp++;
    if (fs[3:2] !== 2'd2) begin
      n_bad++;
      $display("FAIL lu_fwd got %0d want 2", fs[3:2]);
    end
    n_cmp++;
    if (sc !== 16'd1) begin
      n_bad++;
      $display("FAIL lu_cnt got %0d want 1", sc);
    end
    idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_youngest();
    v = 1; we = 1; da = 3'd5;
    @(negedge clk);
    da = 3'd1;
    @(negedge clk);
    da = 3'd5;
    @(negedge clk);
    we = 0; da = 3'd0;
    sa = {3'd5, 3'd5, 3'd1}; su = 3'b101;
    #1;
    n_cmp++;
    if (fs !== 6'b01_00_10) begin
      n_bad++;
      $display("FAIL young_mix got %b want 010010", fs);
    end
    sa = {3'd5, 3'd0, 3'd5}; su = 3'b111;
    #1;
    n_cmp++;
    if (fs !== 6'b01_00_01) begin
      n_bad++;
      $display("FAIL young_dup got %b want 010001", fs);
    end
    v = 0;
    #1;
    n_cmp++;
    if (fs !== 6'd0) begin
      n_bad++;
      $display("FAIL young_novalid got %b want 0", fs);
    end
    idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_flush_stall();
    v = 1; we = 1; ld = 1; da = 3'd4; su = '0;
    @(negedge clk);
    ld = 0; da = 3'd6; fl = 1;
    sa = {3'd0, 3'd0, 3'd4}; su = 3'b001;
    #1;
    n_cmp++;
    if (hz !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_hz got %b want 0", hz);
    end
    @(negedge clk);
    fl = 0; ld = 1; da = 3'd5;
    sa = {3'd0, 3'd6, 3'd4}; su = 3'b011;
    #1;
    n_cmp++;
    if (fs !== 6'b00_00_10) begin
      n_bad++;
      $display("FAIL flush_bubble got %b want 000010", fs);
    end
    n_cmp++;
    if (hz !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_nohz got %b want 0", hz);
    end
    @(negedge clk);
    se = 1; we = 0; ld = 0; da = 3'd0;
    sa = {3'd0, 3'd4, 3'd5}; su = 3'b011;
    #1;
    n_cmp++;
    if (hz !== 1'b1 || fs !== 6'b00_11_00) begin
      n_bad++;
      $display("FAIL ext_pre got hz=%b sel=%b want 1 001100",
               hz, fs);
    end
    repeat (4) @(negedge clk);
    #1;
    n_cmp++;
    if (fs !== 6'b00_11_00) begin
      n_bad++;
      $display("FAIL ext_hold_sel got %b want 001100", fs);
    end
    n_cmp++;
    if (hz !== 1'b1) begin
      n_bad++;
      $display("FAIL ext_hold_hz got %b want 1", hz);
    end
    n_cmp++;
    if (sc !== 16'd1) begin
      n_bad++;
      $display("FAIL ext_hold_cnt got %0d want 1", sc);
    end
    se = 0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (fs !== 6'b00_00_10) begin
      n_bad++;
      $display("FAIL ext_rel_sel got %b want 000010", fs);
    end
    n_cmp++;
    if (hz !== 1'b0) begin
      n_bad++;
      $display("FAIL ext_rel_hz got %b want 0", hz);
    end
    n_cmp++;
    if (sc !== 16'd2) begin
      n_bad++;
      $display("FAIL ext_rel_cnt got %0d want 2", sc);
    end
    idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    v = 1; we = 1; da = 3'd1;
    @(negedge clk);
    da = 3'd2;
    @(negedge clk);
    da = 3'd3;
    @(negedge clk);
    we = 0; da = 3'd0;
    sa = {3'd3, 3'd2, 3'd1}; su = 3'b111;
    #1;
    n_cmp++;
    if (fs !== 6'b01_10_11) begin
      n_bad++;
      $display("FAIL mid_pre got %b want 011011", fs);
    end
    #1 rst_n = 0;
    #1;
    n_cmp++;
    if (fs !== 6'd0) begin
      n_bad++;
      $display("FAIL mid_sel got %b want 0", fs);
    end
    n_cmp++;
    if (hz !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_hz got %b want 0", hz);
    end
    n_cmp++;
    if (sc !== 16'd0) begin
      n_bad++;
      $display("FAIL mid_cnt got %0d want 0", sc);
    end
    #1 rst_n = 1;
    idle();
    @(negedge clk);
  endtask

  task automatic test_param_sweep();
    pv = 1; pwe = 1; pld = 1; pda = 5'd9; psu = '0;
    @(negedge clk);
    pwe = 0; pld = 0; pda = 5'd0;
    psa = {5'd0, 5'd9}; psu = 2'b01;
    #1;
    n_cmp++;
    if (phz !== 1'b1 || pfs[2:0] !== 3'd0) begin
      n_bad++;
      $display("FAIL p_s1 got hz=%b sel=%0d want 1 0",
               phz, pfs[2:0]);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (phz !== 1'b1 || pfs[2:0] !== 3'd0) begin
      n_bad++;
      $display("FAIL p_s2 got hz=%b sel=%0d want 1 0",
               phz, pfs[2:0]);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (phz !== 1'b0 || pfs[2:0] !== 3'd3) begin
      n_bad++;
      $display("FAIL p_s3 got hz=%b sel=%0d want 0 3",
               phz, pfs[2:0]);
    end
    n_cmp++;
    if (pcnt !== 4'd2) begin
      n_bad++;
      $display("FAIL p_cnt got %0d want 2", pcnt);
    end
    pwe = 1; pld = 1; pda = 5'd9;
    repeat (30) @(negedge clk);
    #1;
    n_cmp++;
    if (pcnt !== 4'hF) begin
      n_bad++;
      $display("FAIL p_sat got %0d want 15", pcnt);
    end
    repeat (6) @(negedge clk);
    #1;
    n_cmp++;
    if (pcnt !== 4'hF) begin
      n_bad++;
      $display("FAIL p_sat_hold got %0d want 15", pcnt);
    end
    pv = 0; pwe = 0; pld = 0; psu = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    @(negedge clk);
    test_back_to_back();
    test_load_use();
    test_youngest();
    test_flush_stall();
    test_reset_mid();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
